// File: rtl/tod_pkg.sv
// rtl/tod_pkg.sv - shared field-select encoding and 12-hour view helper
package tod_pkg;

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HR   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Midnight and noon both show as 12; afternoon hours fold down by 12.
  function automatic int unsigned hr12_view(input int unsigned h);
    if (h == 0) begin
      return 12;
    end else if (h > 12) begin
      return h - 12;
    end else begin
      return h;
    end
  endfunction

endpackage

// File: rtl/mod_counter_stage.sv
// rtl/mod_counter_stage.sv - one modulo-MOD up/down stage with load, set-increment and wrap pulse
module mod_counter_stage #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c,
  input  logic         dn,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         zC,
  output logic         ld_err
);

  localparam logic [W-1:0] TOP  = W'(MOD - 1);
  localparam logic [W:0]   MODV = (W + 1)'(MOD);

  logic ld_ok;
  logic at_edge;

  assign ld_ok   = ({1'b0, ld_val} < MODV);
  assign at_edge = dn ? (q == '0) : (q == TOP);

  // Wrap pulse only for a genuine count; loads, set-increments and reset never carry.
  assign zC = c & ~rst & ~ld & ~inc & at_edge;

  // Field register and rejected-load flag, priority rst > ld > inc > c.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      ld_err <= 1'b0;
    end else begin
      ld_err <= ld & ~ld_ok;
      if (ld) begin
        if (ld_ok) begin
          q <= ld_val;
        end
      end else if (inc) begin
        q <= (q == TOP) ? '0 : q + W'(1);
      end else if (c) begin
        if (dn) begin
          q <= (q == '0) ? TOP : q - W'(1);
        end else begin
          q <= (q == TOP) ? '0 : q + W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tod_counter_chain.sv
// rtl/tod_counter_chain.sv - seconds/minutes/hours chain with field load, set-increment and 12-hour view
module tod_counter_chain
  import tod_pkg::*;
#(
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int HR_MOD  = 24,
  parameter int W       = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c,
  input  logic         dn,
  input  logic         ld,
  input  logic [1:0]   sel,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic [W-1:0] hr,
  output logic [W-1:0] hr12,
  output logic         pm,
  output logic         sec_zC,
  output logic         min_zC,
  output logic         hr_zC,
  output logic         ld_err
);

  logic cnt;
  logic ld_s, ld_m, ld_h;
  logic inc_s, inc_m, inc_h;
  logic err_s, err_m, err_h;

  // Any load or set-increment freezes counting for the whole chain, not just the selected field.
  assign cnt = c & ~ld & ~inc;

  assign ld_s  = ld & (sel == SEL_SEC);
  assign ld_m  = ld & (sel == SEL_MIN);
  assign ld_h  = ld & (sel == SEL_HR);
  assign inc_s = inc & ~ld & (sel == SEL_SEC);
  assign inc_m = inc & ~ld & (sel == SEL_MIN);
  assign inc_h = inc & ~ld & (sel == SEL_HR);

  mod_counter_stage #(.MOD(SEC_MOD), .W(W)) u_sec (
    .clk(clk), .rst(rst), .c(cnt), .dn(dn), .ld(ld_s), .ld_val(ld_val), .inc(inc_s),
    .q(sec), .zC(sec_zC), .ld_err(err_s)
  );

  mod_counter_stage #(.MOD(MIN_MOD), .W(W)) u_min (
    .clk(clk), .rst(rst), .c(sec_zC), .dn(dn), .ld(ld_m), .ld_val(ld_val), .inc(inc_m),
    .q(min), .zC(min_zC), .ld_err(err_m)
  );

  mod_counter_stage #(.MOD(HR_MOD), .W(W)) u_hr (
    .clk(clk), .rst(rst), .c(min_zC), .dn(dn), .ld(ld_h), .ld_val(ld_val), .inc(inc_h),
    .q(hr), .zC(hr_zC), .ld_err(err_h)
  );

  assign ld_err = err_s | err_m | err_h;

  // The 12-hour view is only meaningful for a 24-hour day; otherwise pass hours through.
  assign hr12 = (HR_MOD == 24) ? W'(hr12_view(32'(hr))) : hr;
  assign pm   = (HR_MOD == 24) && (32'(hr) >= 32'd12);

endmodule

// File: tb/tb_tod_counter_chain.sv
// tb/tb_tod_counter_chain.sv - randomized and directed bench against a seconds-of-day reference model
module tb_tod_counter_chain;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst, c, dn, ld, inc;
  logic [1:0]   sel;
  logic [W-1:0] ld_val;
  logic [W-1:0] sec, min, hr, hr12;
  logic         pm, sec_zC, min_zC, hr_zC, ld_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: time of day as a single seconds count, plus pending load error
  int t = 0;
  bit m_err = 1'b0;

  tod_counter_chain #(.SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24), .W(W)) dut (
    .clk(clk), .rst(rst), .c(c), .dn(dn), .ld(ld), .sel(sel), .ld_val(ld_val), .inc(inc),
    .sec(sec), .min(min), .hr(hr), .hr12(hr12), .pm(pm),
    .sec_zC(sec_zC), .min_zC(min_zC), .hr_zC(hr_zC), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic int fmod(input int s);
    return (s == 2) ? 24 : 60;
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, then advance the model.
  task automatic cyc(input bit r, input bit cc, input bit d, input bit l,
                     input int s, input int v, input bit i);
    int h, mi, se;
    int f[3];
    bit cnt, e0, e1, e2, nerr;
    @(negedge clk);
    rst = r; c = cc; dn = d; ld = l; sel = 2'(s); ld_val = W'(v); inc = i;
    #1;
    h  = t / 3600;
    mi = (t / 60) % 60;
    se = t % 60;
    chk("sec", 32'(sec), se);
    chk("min", 32'(min), mi);
    chk("hr", 32'(hr), h);
    chk("hr12", 32'(hr12), (h + 11) % 12 + 1);
    chk("pm", 32'(pm), (h >= 12) ? 1 : 0);
    chk("ld_err", 32'(ld_err), 32'(m_err));
    cnt = cc && !l && !i && !r;
    if (d) begin
      e0 = cnt && (t % 60 == 0);
      e1 = cnt && (t % 3600 == 0);
      e2 = cnt && (t == 0);
    end else begin
      e0 = cnt && ((t + 1) % 60 == 0);
      e1 = cnt && ((t + 1) % 3600 == 0);
      e2 = cnt && ((t + 1) % 86400 == 0);
    end
    chk("sec_zC", 32'(sec_zC), 32'(e0));
    chk("min_zC", 32'(min_zC), 32'(e1));
    chk("hr_zC", 32'(hr_zC), 32'(e2));
    nerr = 1'b0;
    f[0] = se; f[1] = mi; f[2] = h;
    if (r) begin
      t = 0;
    end else if (l) begin
      if (s < 3) begin
        if (v < fmod(s)) f[s] = v;
        else nerr = 1'b1;
      end
      t = f[2] * 3600 + f[1] * 60 + f[0];
    end else if (i) begin
      if (s < 3) f[s] = (f[s] + 1) % fmod(s);
      t = f[2] * 3600 + f[1] * 60 + f[0];
    end else if (cnt) begin
      t = d ? (t + 86399) % 86400 : (t + 1) % 86400;
    end
    m_err = nerr;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 3, 0, 0);
  endtask

  // Read registers just after the edge that closed the previous cycle.
  task automatic peek(input string tag, input int es, input int em, input int eh);
    @(posedge clk);
    #1;
    chk({tag, "_sec"}, 32'(sec), es);
    chk({tag, "_min"}, 32'(min), em);
    chk({tag, "_hr"}, 32'(hr), eh);
  endtask

  initial begin
    int hs[5];
    rst = 1'b1; c = 0; dn = 0; ld = 0; inc = 0; sel = 2'd3; ld_val = '0;
    cyc(1, 0, 0, 0, 3, 0, 0);
    cyc(1, 1, 0, 0, 3, 0, 0);
    peek("reset", 0, 0, 0);

    // 60 up counts: seconds wrap once into minutes
    for (int k = 0; k < 60; k++) cyc(0, 1, 0, 0, 3, 0, 0);
    peek("sixty", 0, 1, 0);

    // full ripple up from 23:59:59
    cyc(0, 0, 0, 1, 2, 23, 0);
    cyc(0, 0, 0, 1, 1, 59, 0);
    cyc(0, 0, 0, 1, 0, 59, 0);
    peek("preset", 59, 59, 23);
    cyc(0, 1, 0, 0, 3, 0, 0);
    peek("ripple_up", 0, 0, 0);

    // full ripple down from midnight, then a plain step down
    cyc(0, 1, 1, 0, 3, 0, 0);
    peek("ripple_dn", 59, 59, 23);
    cyc(0, 1, 1, 0, 3, 0, 0);
    peek("step_dn", 58, 59, 23);

    // out-of-range load rejected, sel 3 ignored
    cyc(0, 0, 0, 1, 1, 7, 0);
    cyc(0, 0, 0, 1, 1, 60, 0);
    idle();
    cyc(0, 0, 0, 1, 3, 5, 0);
    idle();
    peek("rejected", 58, 7, 23);

    // set-increment wraps minutes without carry; ld beats inc and c
    cyc(0, 0, 0, 1, 1, 59, 0);
    cyc(0, 1, 0, 0, 1, 0, 1);
    peek("inc_wrap", 58, 0, 23);
    cyc(0, 1, 0, 1, 0, 3, 1);
    peek("ld_wins", 3, 0, 23);

    // 12-hour view at the calendar corners
    hs[0] = 0; hs[1] = 11; hs[2] = 12; hs[3] = 13; hs[4] = 23;
    foreach (hs[k]) begin
      cyc(0, 0, 0, 1, 2, hs[k], 0);
      idle();
    end

    // reset beats a ripple in progress
    cyc(0, 0, 0, 1, 2, 23, 0);
    cyc(0, 0, 0, 1, 1, 59, 0);
    cyc(0, 0, 0, 1, 0, 59, 0);
    cyc(1, 1, 0, 0, 3, 0, 0);
    peek("rst_ripple", 0, 0, 0);

    // randomized traffic, biased toward counting with boundary-heavy loads
    for (int k = 0; k < 4000; k++) begin
      int p, s, v;
      p = $urandom_range(0, 99);
      s = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) v = fmod(s < 3 ? s : 0) - 1 + $urandom_range(0, 2) - 1;
      else v = $urandom_range(0, 63);
      if (v < 0) v = 0;
      if (p < 2)       cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, s, v, 0);
      else if (p < 12) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, s, v, $urandom_range(0, 1));
      else if (p < 20) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, s, v, 1);
      else if (p < 90) cyc(0, 1, (k / 500) % 2 == 1, 0, s, v, 0);
      else             cyc(0, 0, $urandom_range(0, 1), 0, s, v, 0);
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tod_counter_chain.md
# tod_counter_chain

Parametrised time-of-day counter chain: seconds, minutes and hours stages, each with a configurable modulus. Adds up/down counting, per-field parallel load, carry-free set-increment for clock setting, load range checking and a 12-hour display view. It sits between the 1 Hz count-enable source and the display/alarm-compare logic, and replaces the fixed seconds/minutes/hours counter trio.

## Interface
Parameters:
- SEC_MOD, 60, seconds-stage modulus (2..64)
- MIN_MOD, 60, minutes-stage modulus (2..64)
- HR_MOD, 24, hours-stage modulus (2..64); 12-hour view valid only when HR_MOD == 24
- W, 6, field width; must satisfy 2^W >= max modulus

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- c  in  1  count enable; one-cycle pulse advances seconds by one
- dn  in  1  direction: 0 = up, 1 = down; sampled with c
- ld  in  1  parallel load strobe
- sel  in  2  field select for ld/inc: 0 = sec, 1 = min, 2 = hr, 3 = none
- ld_val  in  W  load value
- inc  in  1  set-increment strobe for the selected field, no carry out
- sec  out  W  seconds value
- min  out  W  minutes value
- hr  out  W  hours value (0..HR_MOD-1)
- hr12  out  W  12-hour view (1..12)
- pm  out  1  1 when hr >= 12 (HR_MOD == 24 only, else 0)
- sec_zC  out  1  seconds wrap pulse
- min_zC  out  1  minutes wrap pulse
- hr_zC  out  1  hours (day) wrap pulse
- ld_err  out  1  registered one-cycle pulse: rejected load

## Operation
- Priority, evaluated per cycle: rst > ld > inc > c.
- rst: sec = min = hr = 0, ld_err = 0. All zC outputs are 0 while rst is high.
- ld with sel 0..2: selected field <= ld_val if ld_val < that field's modulus. Otherwise the field is unchanged and ld_err pulses next cycle. sel = 3 is a no-op with no error. Counting is suppressed in any cycle where ld is high.
- inc (ld low): selected field increments modulo its MOD. Always up, regardless of dn. Generates no zC and no carry. Counting is suppressed in that cycle.
- c (ld and inc low), up: sec increments. sec_zC = c & !dn & (sec == SEC_MOD-1). When sec_zC is high, sec wraps to 0 and min advances. The same rule applies to min → hr via min_zC, and hr wraps via hr_zC.
- c, down: sec decrements. sec_zC = c & dn & (sec == 0). When sec_zC is high, sec wraps to SEC_MOD-1 and min decrements. The same rule applies to min and hr.
- zC outputs are combinational from current state, c and dn, and are suppressed when ld, inc or rst is high. Full ripple happens in one cycle: 23:59:59 up → 00:00:00 with all three zC high in that cycle.
- hr12: 12 when hr == 0; hr-12 when hr > 12; otherwise hr. When HR_MOD != 24, hr12 = hr and pm = 0.

## Timing
- Field update latency: 1 cycle. The edge where c/ld/inc is sampled high updates the registers.
- zC: same cycle as the causing c (zero latency). It is valid for chaining into downstream enables.
- ld_err: asserted the cycle after the rejected ld, for exactly one cycle.
- hr12/pm: combinational from hr, so they update in the same cycle as hr.
- c held high for N cycles advances N seconds. No edge detection is done here.
- rst asserted mid-ripple (e.g. during a c pulse at 23:59:59) wins: next state is 00:00:00 and no zC is asserted.

## Structure
- Package tod_pkg: sel encoding constants (SEL_SEC, SEL_MIN, SEL_HR, SEL_NONE) and a function computing the 12-hour view.
- Sub-module mod_counter_stage, parameters MOD and W. Inputs: clk, rst, c, dn, ld, ld_val, inc. Outputs: q, zC, ld_err. Instantiated three times and chained zC → c. The top level handles sel decode and the hr12/pm view, and ORs the ld_err outputs.

## Test plan
- Reset, then 60 c pulses with dn = 0 → sec 59 → 0, sec_zC high for exactly 1 cycle, min = 1.
- ld sel = 2 value 23, ld sel = 1 value 59, ld sel = 0 value 59, then one c pulse → 00:00:00; sec_zC, min_zC and hr_zC all high in that cycle.
- From 00:00:00, dn = 1 with one c pulse → 23:59:59 with all three zC high. A second c pulse → 23:59:58 with no zC.
- ld sel = 1 with ld_val = 60 while min = 7 → min stays 7, ld_err high for one cycle. ld sel = 3 value 5 → no change, no ld_err.
- inc sel = 1 at min = 59 → min = 0, hr unchanged, min_zC stays low. ld, inc and c high together → only the load takes effect.
- hr = 0/11/12/13/23 → hr12 = 12/11/12/1/11, pm = 0/0/1/1/1. rst during c at 23:59:59 → 00:00:00, no zC.
